chdr_strip_sched: RTL and testbench

- Packet-atomic round-robin scheduler that shares one CHDR header-strip datapath between NUM_PORTS CHDR input streams.
- Selects one requester per packet and forwards the packet through a registered output stage.
- Supplies the per-port strip decision (m_strip_en) and source port index (m_port), both stable for the whole packet, so the downstream strip block samples strip_en on the first word.
- Sits between per-port CHDR sources and a single strip/egress path.

---
 rtl/chdr_strip_sched.sv | 159 +++++++++++++++
 tb/tb_chdr_strip_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chdr_strip_sched.sv
// ----------------------------------------------------------------------------
// chdr_strip_sched
//
// Packet-atomic round-robin scheduler. It shares one CHDR header-strip
// datapath between NUM_PORTS input streams. One requester is granted per
// packet, and its words pass through a single registered output stage.
// Alongside the data, the block presents the strip decision and the source
// port. Both stay constant for the whole packet, so the downstream strip
// block can sample m_strip_en on the first word.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   arb_en            1 = new grants allowed; 0 = finish current packet, idle
//   cfg_strip_en      per-port strip enable, sampled when the port is granted
//   s_chdr_*          NUM_PORTS AXI-Stream inputs (port i data at i*CHDR_W)
//   m_chdr_*          single AXI-Stream output (registered)
//   m_strip_en        strip decision for the packet currently on the output
//   m_port            source port of the packet currently on the output
// ----------------------------------------------------------------------------
module chdr_strip_sched #(
    parameter  int CHDR_W    = 64,
    parameter  int NUM_PORTS = 4,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [NUM_PORTS-1:0]          cfg_strip_en,
    input  logic [NUM_PORTS*CHDR_W-1:0]   s_chdr_tdata,
    input  logic [NUM_PORTS-1:0]          s_chdr_tlast,
    input  logic [NUM_PORTS-1:0]          s_chdr_tvalid,
    output logic [NUM_PORTS-1:0]          s_chdr_tready,
    output logic [CHDR_W-1:0]             m_chdr_tdata,
    output logic                          m_chdr_tlast,
    output logic                          m_chdr_tvalid,
    input  logic                          m_chdr_tready,
    output logic                          m_strip_en,
    output logic [PORT_W-1:0]             m_port
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    // grant_q is both the current grant and the last grant. Its reset value
    // NUM_PORTS-1 makes port 0 the first candidate of the search.
    logic [PORT_W-1:0]   grant_q,     grant_d;
    logic                strip_lat_q, strip_lat_d;

    logic                m_valid_q,   m_valid_d;
    logic                m_last_q,    m_last_d;
    logic [CHDR_W-1:0]   m_data_q,    m_data_d;
    logic                m_strip_q,   m_strip_d;
    logic [PORT_W-1:0]   m_port_q,    m_port_d;

    logic                out_ready;
    logic                in_beat;
    logic                arb_found;
    logic [PORT_W-1:0]   arb_port;

    // The output register can take a word when it is empty or being drained.
    assign out_ready = !m_valid_q || m_chdr_tready;

    // Ready depends only on state, grant and output space, never on tvalid.
    always_comb begin
        s_chdr_tready = '0;
        if (state_q == ST_PKT && out_ready) begin
            s_chdr_tready[grant_q] = 1'b1;
        end
    end

    assign in_beat = (state_q == ST_PKT) && out_ready && s_chdr_tvalid[grant_q];

    // Round-robin search starts at grant_q+1 and wraps at NUM_PORTS-1 -> 0.
    // Index values at or above NUM_PORTS are never produced.
    always_comb begin
        int unsigned idx;
        arb_found = 1'b0;
        arb_port  = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = (int'(grant_q) + i) % NUM_PORTS;
            if (!arb_found && s_chdr_tvalid[idx]) begin
                arb_found = 1'b1;
                arb_port  = PORT_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        strip_lat_d = strip_lat_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        m_strip_d   = m_strip_q;
        m_port_d    = m_port_q;

        // The output stage keeps draining in IDLE too, so the last word of a
        // packet leaves even while the next grant is being decided.
        if (in_beat) begin
            m_valid_d = 1'b1;
            m_last_d  = s_chdr_tlast[grant_q];
            m_data_d  = s_chdr_tdata[int'(grant_q)*CHDR_W +: CHDR_W];
            m_strip_d = strip_lat_q;
            m_port_d  = grant_q;
        end else if (m_chdr_tready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_en && arb_found) begin
                    grant_d     = arb_port;
                    strip_lat_d = cfg_strip_en[arb_port];
                    state_d     = ST_PKT;
                end
            end
            ST_PKT: begin
                if (in_beat && s_chdr_tlast[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= PORT_W'(NUM_PORTS - 1);
            strip_lat_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            m_strip_q   <= 1'b0;
            m_port_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            strip_lat_q <= strip_lat_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            m_strip_q   <= m_strip_d;
            m_port_q    <= m_port_d;
        end
    end

    assign m_chdr_tvalid = m_valid_q;
    assign m_chdr_tlast  = m_last_q;
    assign m_chdr_tdata  = m_data_q;
    assign m_strip_en    = m_strip_q;
    assign m_port        = m_port_q;

endmodule

// File: tb/tb_chdr_strip_sched.sv
// ----------------------------------------------------------------------------
// tb_chdr_strip_sched
//
// Self-checking bench for chdr_strip_sched. Each port has a queue of source
// words. Each port also has a queue of words expected at the output. A
// negedge compare process checks every output word against a packet-level
// model with these rules:
//   - The next packet comes from the first port with pending words, counting
//     from last port + 1.
//   - Words are delivered whole and in order.
//   - The strip bit is the one chosen for that packet.
//   - Output is held while stalled.
// Directed phases pin the model with literal expectations.
// ----------------------------------------------------------------------------
module tb_chdr_strip_sched;

    localparam int NP = 4;
    localparam int W  = 64;
    localparam int PW = $clog2(NP);

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic         strip;
    } word_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arb_en;
    logic [NP-1:0]     cfg_strip_en;
    logic [NP*W-1:0]   s_tdata;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [W-1:0]      m_tdata;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_strip;
    logic [PW-1:0]     m_port;

    chdr_strip_sched #(.CHDR_W(W), .NUM_PORTS(NP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arb_en        (arb_en),
        .cfg_strip_en  (cfg_strip_en),
        .s_chdr_tdata  (s_tdata),
        .s_chdr_tlast  (s_tlast),
        .s_chdr_tvalid (s_tvalid),
        .s_chdr_tready (s_tready),
        .m_chdr_tdata  (m_tdata),
        .m_chdr_tlast  (m_tlast),
        .m_chdr_tvalid (m_tvalid),
        .m_chdr_tready (m_tready),
        .m_strip_en    (m_strip),
        .m_port        (m_port)
    );

    initial forever #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;

    word_t srcq [NP][$];
    word_t expq [NP][$];
    logic  started [NP];
    int    seq = 0;

    // knobs
    logic  rand_mode = 1'b0;
    int    bubble_pct = 0;
    int    flip_pct = 0;

    // checker state and logs
    logic           in_pkt = 1'b0;
    int             last_port = NP-1;
    int             cur_port = 0;
    logic           stall_prev = 1'b0;
    logic [W-1:0]   hold_data;
    logic           hold_last, hold_strip;
    logic [PW-1:0]  hold_port;
    int             words_out = 0;
    int             pkt_port[$];
    int             pkt_strip[$];
    int             out_cyc[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Queue one packet on port p. The strip bit is presented on cfg as soon as
    // the packet becomes the port's head.
    task automatic push_pkt(input int p, input int len, input logic strip);
        word_t w;
        if (srcq[p].size() == 0) cfg_strip_en[p] = strip;
        for (int i = 0; i < len; i++) begin
            w.data  = {8'(p), 24'(seq * 16 + i), 32'($urandom)};
            w.last  = (i == len - 1);
            w.strip = strip;
            srcq[p].push_back(w);
            expq[p].push_back(w);
        end
        seq++;
    endtask

    task automatic model_flush();
        for (int p = 0; p < NP; p++) begin
            srcq[p].delete();
            expq[p].delete();
            started[p] = 1'b0;
        end
        cfg_strip_en = '0;
        s_tvalid     = '0;
        in_pkt       = 1'b0;
        last_port    = NP-1;
        stall_prev   = 1'b0;
    endtask

    function automatic int pending();
        int n = 0;
        for (int p = 0; p < NP; p++) n += srcq[p].size() + expq[p].size();
        return n;
    endfunction

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (pending() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (pending() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: drain timeout, %0d words left, required 0", name, pending());
        end
        repeat (2) @(posedge clk);
        #3;
    endtask

    // Source driver: retire accepted words, then present each port's head word.
    initial begin
        logic [NP-1:0] acc;
        for (int p = 0; p < NP; p++) started[p] = 1'b0;
        forever begin
            @(negedge clk);
            acc = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (acc[p] && srcq[p].size() > 0) begin
                    if (srcq[p][0].last) begin
                        started[p] = 1'b0;
                        void'(srcq[p].pop_front());
                        if (srcq[p].size() > 0) cfg_strip_en[p] = srcq[p][0].strip;
                    end else begin
                        started[p] = 1'b1;
                        void'(srcq[p].pop_front());
                    end
                end else if (started[p] && ($urandom % 100) < flip_pct) begin
                    // mid-packet config churn must not reach the current packet
                    cfg_strip_en[p] = ~cfg_strip_en[p];
                end
                if (srcq[p].size() > 0) begin
                    s_tvalid[p]        = !started[p] || (($urandom % 100) >= bubble_pct);
                    s_tdata[p*W +: W]  = srcq[p][0].data;
                    s_tlast[p]         = srcq[p][0].last;
                end else begin
                    s_tvalid[p] = 1'b0;
                    s_tlast[p]  = 1'b0;
                end
            end
            if (rand_mode) begin
                m_tready = ($urandom % 4) != 0;
                arb_en   = ($urandom % 8) != 0;
            end
        end
    end

    // Compare process
    initial forever begin
        word_t e;
        int    ep;
        @(negedge clk);
        if (rst_n) begin
            if (stall_prev) begin
                chk("hold_valid", W'(m_tvalid), W'(1));
                chk("hold_data",  m_tdata, hold_data);
                chk("hold_last",  W'(m_tlast), W'(hold_last));
                chk("hold_strip", W'(m_strip), W'(hold_strip));
                chk("hold_port",  W'(m_port), W'(hold_port));
            end
            if (m_tvalid && m_tready) begin
                if (!in_pkt) begin
                    ep = -1;
                    for (int i = 1; i <= NP; i++)
                        if (ep < 0 && expq[(last_port + i) % NP].size() > 0) ep = (last_port + i) % NP;
                    if (ep < 0) ep = int'(m_port);
                    chk("grant_order", W'(m_port), W'(ep));
                    cur_port = ep;
                    in_pkt   = 1'b1;
                    pkt_port.push_back(int'(m_port));
                    pkt_strip.push_back(int'(m_strip));
                end
                out_cyc.push_back(cyc);
                words_out++;
                if (expq[cur_port].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %0h on port %0d, required no word", m_tdata, m_port);
                end else begin
                    e = expq[cur_port].pop_front();
                    chk("data",  m_tdata, e.data);
                    chk("last",  W'(m_tlast), W'(e.last));
                    chk("strip", W'(m_strip), W'(e.strip));
                    chk("port",  W'(m_port), W'(cur_port));
                end
                if (m_tlast) begin
                    in_pkt    = 1'b0;
                    last_port = cur_port;
                end
            end
            stall_prev = m_tvalid && !m_tready;
            hold_data  = m_tdata;
            hold_last  = m_tlast;
            hold_strip = m_strip;
            hold_port  = m_port;
        end
    end

    initial begin
        int n0, w0, c0, bound;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [7:0] tr_pat = 8'b1110_1001;   // applied LSB first: 1,0,0,1,0,1,1,1

        rst_n = 1'b0; arb_en = 1'b1; cfg_strip_en = '0;
        s_tdata = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_tvalid", W'(m_tvalid), W'(0));
        chk("rst_tlast",  W'(m_tlast),  W'(0));
        chk("rst_strip",  W'(m_strip),  W'(0));
        chk("rst_port",   W'(m_port),   W'(0));
        chk("rst_tready", W'(s_tready), W'(0));
        rst_n = 1'b1;
        @(posedge clk); #3;

        // port 2 alone, 3 words, strip on
        c0 = cyc;
        push_pkt(2, 3, 1'b1);
        wait_drain("t1", 50);
        chk("t1_pkts",    W'(pkt_port.size()), W'(1));
        chk("t1_port",    W'(pkt_port[0]), W'(2));
        chk("t1_strip",   W'(pkt_strip[0]), W'(1));
        chk("t1_latency", W'(out_cyc[0] - c0), W'(3));
        chk("t1_words",   W'(words_out), W'(3));

        // fresh reset, all four ports, 2-word packets, back to back
        rst_n = 1'b0; model_flush();
        repeat (2) @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #3;
        n0 = pkt_port.size(); w0 = words_out;
        for (int k = 0; k < 5; k++) push_pkt(exp_order[k], 2, 1'($urandom));
        wait_drain("t2", 100);
        for (int k = 0; k < 5; k++) chk("t2_order", W'(pkt_port[n0 + k]), W'(exp_order[k]));
        chk("t2_span", W'(out_cyc[w0 + 9] - out_cyc[w0]), W'(13));

        // stall pattern on a 4-word packet
        w0 = words_out;
        m_tready = 1'b0;
        push_pkt(1, 4, 1'b0);
        bound = 0;
        while (!m_tvalid && bound < 20) begin @(posedge clk); #3; bound++; end
        chk("t3_first_valid", W'(m_tvalid), W'(1));
        for (int i = 0; i < 8; i++) begin
            m_tready = tr_pat[i];
            @(posedge clk); #3;
        end
        m_tready = 1'b1;
        wait_drain("t3", 50);
        chk("t3_words", W'(words_out - w0), W'(4));

        // strip config toggling inside a packet, then a second packet
        n0 = pkt_port.size();
        flip_pct = 100;
        push_pkt(1, 4, 1'b1);
        push_pkt(1, 2, 1'b0);
        wait_drain("t4", 60);
        flip_pct = 0;
        chk("t4_strip_a", W'(pkt_strip[n0]), W'(1));
        chk("t4_strip_b", W'(pkt_strip[n0 + 1]), W'(0));

        // arb_en dropped during port 0's packet while port 1 waits
        n0 = pkt_port.size(); w0 = words_out;
        push_pkt(0, 5, 1'b0);
        push_pkt(1, 1, 1'b1);
        bound = 0;
        while (words_out == w0 && bound < 20) begin @(posedge clk); #3; bound++; end
        arb_en = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        chk("t5_held_pkts",  W'(pkt_port.size() - n0), W'(1));
        chk("t5_held_words", W'(words_out - w0), W'(5));
        chk("t5_p1_waiting", W'(expq[1].size()), W'(1));
        arb_en = 1'b1;
        wait_drain("t5", 50);
        chk("t5_resume", W'(pkt_port[pkt_port.size() - 1]), W'(1));

        // reset in the middle of a packet
        w0 = words_out;
        push_pkt(1, 4, 1'b1);
        bound = 0;
        while (words_out == w0 && bound < 20) begin @(posedge clk); #3; bound++; end
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", W'(m_tvalid), W'(0));
        chk("t6_async_strip", W'(m_strip), W'(0));
        chk("t6_async_ready", W'(s_tready), W'(0));
        model_flush();
        repeat (2) @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #3;
        n0 = pkt_port.size();
        push_pkt(3, 2, 1'b0);
        push_pkt(0, 2, 1'b1);
        wait_drain("t6", 50);
        chk("t6_first", W'(pkt_port[n0]), W'(0));
        chk("t6_second", W'(pkt_port[n0 + 1]), W'(3));

        // randomized traffic
        w0 = words_out;
        for (int k = 0; k < 8; k++)
            for (int p = 0; p < NP; p++) push_pkt(p, int'($urandom_range(1, 6)), 1'($urandom));
        bubble_pct = 20; flip_pct = 20; rand_mode = 1'b1;
        wait_drain("rand", 4000);
        rand_mode = 1'b0; bubble_pct = 0; flip_pct = 0;
        @(posedge clk); #1;
        m_tready = 1'b1; arb_en = 1'b1;
        repeat (3) @(posedge clk); #3;
        chk("rand_idle", W'(m_tvalid), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
